// File: rtl/c17_seq_pkg.sv
// Shared types and constants for the c17 stimulus/compare sequencer.
package c17_seq_pkg;

  localparam int VEC_W = 5;  // {N1,N2,N3,N6,N7}
  localparam int OUT_W = 2;  // {N22_reg,N23_reg}

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Travels alongside each applied vector so the compare knows which
  // registered outputs belong to a real vector and which one it was.
  typedef struct packed {
    logic             valid;
    logic [VEC_W-1:0] vector;
  } tag_t;

  // Per-output disagreement between the golden and faulty instances.
  function automatic logic [OUT_W-1:0] out_diff(input logic [OUT_W-1:0] golden,
                                                input logic [OUT_W-1:0] faulty);
    return golden ^ faulty;
  endfunction

endpackage

// File: rtl/c17_seq_tagpipe.sv
// LATENCY-deep delay line for (valid, vector) tags, matching the register
// latency of the c17 wrappers so each compare sees its own vector.
module c17_seq_tagpipe
  import c17_seq_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  tag_t tag_in,
  output tag_t tag_out
);

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      tag_t stage_reg;
      if (gi == 0) begin : g_head
        // First stage samples the tag of the vector currently on vec.
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) stage_reg <= '0;
          else        stage_reg <= tag_in;
        end
      end else begin : g_tail
        // Later stages shift the tag one cycle further.
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) stage_reg <= '0;
          else        stage_reg <= g_stage[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign tag_out = g_stage[LATENCY-1].stage_reg;

endmodule

// File: rtl/c17_test_sequencer.sv
// Walks all input vectors through a golden and a fault-injected c17 pair,
// compares their registered outputs and accumulates campaign results.
module c17_test_sequencer
  import c17_seq_pkg::*;
#(
  parameter int NUM_VECTORS = 32,
  parameter int LATENCY     = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec,
  input  logic [OUT_W-1:0] golden_out,
  input  logic [OUT_W-1:0] dut_out,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W-1:0] first_err_vec,
  output logic             first_err_valid,
  output logic [OUT_W-1:0] mismatch_mask
);

  localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VECTORS - 1);
  localparam logic [2:0]       LAST_DRAIN = 3'(LATENCY - 1);

  state_t           state_reg, state_next;
  logic [VEC_W-1:0] issue_cnt_reg;
  logic [2:0]       drain_cnt_reg;

  logic [CNT_W-1:0] err_count_reg;
  logic [VEC_W-1:0] first_err_vec_reg;
  logic             first_err_valid_reg;
  logic [OUT_W-1:0] mismatch_mask_reg;

  tag_t             tag_in, tag_out;
  logic [OUT_W-1:0] diff;
  logic             mismatch;
  logic             accept;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: one pass over the vectors, then drain the pipeline.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = APPLY;
      APPLY:   if (issue_cnt_reg == LAST_VEC) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == LAST_DRAIN) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; vec is forced to zero outside APPLY.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    vec  = '0;
    unique case (state_reg)
      APPLY:   begin busy = 1'b1; vec = issue_cnt_reg; end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Issue and drain counters; the issue counter holds on the last vector
  // instead of wrapping, and both restart from zero outside their state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      issue_cnt_reg <= '0;
      drain_cnt_reg <= '0;
    end else begin
      if (state_reg == APPLY) begin
        if (issue_cnt_reg != LAST_VEC) issue_cnt_reg <= issue_cnt_reg + VEC_W'(1);
      end else begin
        issue_cnt_reg <= '0;
      end
      if (state_reg == DRAIN) drain_cnt_reg <= drain_cnt_reg + 3'd1;
      else                    drain_cnt_reg <= '0;
    end
  end

  assign tag_in.valid  = (state_reg == APPLY);
  assign tag_in.vector = vec;

  c17_seq_tagpipe #(
    .LATENCY (LATENCY)
  ) u_tagpipe (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign accept   = (state_reg == IDLE) && start;
  assign diff     = out_diff(golden_out, dut_out);
  assign mismatch = tag_out.valid && (|diff);

  // Result accumulation: cleared on start accept, updated on tagged
  // mismatches only; the counter saturates rather than wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_count_reg       <= '0;
      first_err_vec_reg   <= '0;
      first_err_valid_reg <= 1'b0;
      mismatch_mask_reg   <= '0;
    end else if (accept) begin
      err_count_reg       <= '0;
      first_err_vec_reg   <= '0;
      first_err_valid_reg <= 1'b0;
      mismatch_mask_reg   <= '0;
    end else if (mismatch) begin
      if (err_count_reg != {CNT_W{1'b1}}) err_count_reg <= err_count_reg + CNT_W'(1);
      mismatch_mask_reg <= mismatch_mask_reg | diff;
      if (!first_err_valid_reg) begin
        first_err_vec_reg   <= tag_out.vector;
        first_err_valid_reg <= 1'b1;
      end
    end
  end

  assign err_count       = err_count_reg;
  assign first_err_vec   = first_err_vec_reg;
  assign first_err_valid = first_err_valid_reg;
  assign mismatch_mask   = mismatch_mask_reg;

endmodule

// File: doc/c17_test_sequencer.md
# c17_test_sequencer

Stimulus/compare controller for the registered c17 fault-emulation pair: it drives one shared input vector into a fault-free (golden) c17 instance and a fault-injected (DUT) c17 instance, walks all vectors once per run, aligns each vector with the 2-cycle register latency of the wrappers, and compares the two registered output pairs. It reports mismatch count, the first failing vector and a sticky per-output mismatch mask to the host-side fault-campaign logic through a start/busy/done handshake.

## Interface
- NUM_VECTORS, default 32: vectors per run, applied 0..NUM_VECTORS-1; range 1..32.
- LATENCY, default 2: cycles from vector presented on vec to matching outputs on golden_out/dut_out; 1..4.
- CNT_W, default 16: width of err_count.

- CLK  in  1  clock; all state on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- start  in  1  run request, sampled in IDLE only.
- busy  out  1  high from the cycle after start accept through the last compare cycle.
- done  out  1  one-cycle pulse after the last compare.
- vec  out  5  {N1,N2,N3,N6,N7} to both c17 instances; 0 when not in APPLY.
- golden_out  in  2  {N22_reg,N23_reg} of golden instance.
- dut_out  in  2  {N22_reg,N23_reg} of faulty instance.
- err_count  out  CNT_W  vectors with any output mismatch; saturating.
- first_err_vec  out  5  vector of first mismatch in the run.
- first_err_valid  out  1  first_err_vec is meaningful.
- mismatch_mask  out  2  sticky OR of golden_out ^ dut_out over compared cycles.

## Operation
- FSM: IDLE -> APPLY (start=1) -> DRAIN (after vector NUM_VECTORS-1 issued) -> DONE (after LATENCY drain cycles) -> IDLE (unconditional, one cycle).
- Start accept clears err_count, first_err_valid, first_err_vec, mismatch_mask.
- APPLY: vec = issue counter, increments by 1 per cycle; counter never wraps within a run.
- A tag pipeline (valid, vector) of depth LATENCY follows vec; compare only when the tag at its output is valid. Outputs in non-tagged cycles are ignored.
- Compare: mismatch = |(golden_out ^ dut_out). On mismatch, err_count += 1, saturating at 2^CNT_W-1; mask |= xor; if first_err_valid=0, capture tag vector and set first_err_valid.
- start during APPLY/DRAIN/DONE ignored; start held high re-arms only from IDLE (back-to-back runs allowed; results of the previous run are cleared on accept).
- Results hold from DONE until the next accepted start.
- RST_N low at any time: FSM to IDLE, tag pipeline invalidated, all outputs 0 immediately; no done is produced for the aborted run.

## Timing
- Reset values: busy 0, done 0, vec 0, err_count 0, first_err_vec 0, first_err_valid 0, mismatch_mask 0.
- start high at edge 0 -> vector i on vec during cycle 1+i (cycle n = period after edge n).
- Compare of vector i in cycle 1+i+LATENCY; result registers update at the end of that cycle.
- busy high cycles 1..NUM_VECTORS+LATENCY; done high in cycle NUM_VECTORS+LATENCY+1 (35 at defaults), results final in that cycle.
- Next start accepted at earliest in the done cycle +1 (IDLE).

## Structure
- Package c17_seq_pkg: state enum (IDLE, APPLY, DRAIN, DONE), VEC_W=5, OUT_W=2, tag struct {valid, vector}.
- Sub-module c17_seq_tagpipe: LATENCY-deep tag delay line, async active-low clear; the remainder (FSM, issue counter, compare/accumulate) lives in c17_test_sequencer.

## Test plan
- Reset: hold RST_N low 3 cycles with random inputs -> all outputs 0; after release, no busy/done without start.
- Clean run: dut_out = golden_out (bench c17 model), start at edge 0 -> vec 0..31 in cycles 1..32, busy cycles 1..34, done cycle 35, err_count 0, first_err_valid 0, mask 00.
- Single fault: bench flips dut bit 0 only for vector 5 -> err_count 1, first_err_vec 5, first_err_valid 1, mask 01.
- Stuck output: dut_out = ~golden_out always -> err_count 32, first_err_vec 0, mask 11; with CNT_W=4 err_count saturates at 15.
- Handshake: start pulsed in cycles 10 and 34 ignored (single done at 35); new start at cycle 37 clears results in the next cycle and reruns cleanly.
- Abort: RST_N low in cycle 12 -> outputs 0 same cycle; after release, no done; new start gives a complete clean run.
